iter_div_unit: RTL and testbench

//  Parametrised iterative restoring divider for the EX stage: DIV/DIVU/REM/REMU, plus W forms when XLEN=64.
//  Two-sided valid/ready handshake; EX stalls on out_valid.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 23 ++
 rtl/iter_div_unit.sv | 172 +++++++++++++++++
 tb/tb_iter_div_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;

    localparam int XLEN_DEFAULT = 64;
    localparam int WORD_BITS    = 32;
    localparam int CNT_W        = $clog2(XLEN_DEFAULT) + 1;

    // Number of restoring steps for an operation of the given width mode.
    function automatic logic [CNT_W-1:0] step_count(input logic word_op, input int xlen);
        return word_op ? CNT_W'(WORD_BITS) : CNT_W'(xlen);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; driven every cycle by the owning divider.
module div_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0]   shifted;
    logic [W-1:0] low;

    assign shifted = {rem_i, bit_i};
    assign low     = {rem_i[W-2:0], bit_i};
    assign q_o     = (shifted >= {1'b0, divisor_i});
    // The true difference is below the divisor, so W-bit wrap-around arithmetic is exact.
    assign rem_o   = q_o ? (low - divisor_i) : low;

endmodule

// File: rtl/iter_div_unit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU, plus W forms) with flush and fast paths.
// Latency: N+2 cycles to out_valid (N=32 word / XLEN), 1 cycle for div-by-zero, overflow and,
// with DIV_EARLY_OUT_EN defined, |dividend| < |divisor|. Backpressure: result held until out_ready.
module iter_div_unit
    import div_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter bit WORD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            div_signed,
    input  logic            divw,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam logic [XLEN-1:0]      MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [WORD_BITS-1:0] MIN_W = {1'b1, {(WORD_BITS-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        r = x;
        for (int i = WORD_BITS; i < XLEN; i++) r[i] = x[WORD_BITS-1];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        r = x;
        for (int i = WORD_BITS; i < XLEN; i++) r[i] = 1'b0;
        return r;
    endfunction

    div_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] dvd_q, dvs_q, rem_q;
    logic            neg_q_q, neg_r_q, word_q;
    logic            in_ready_q, out_valid_q;
    logic [XLEN-1:0] quotient_q, remainder_q;

    logic            word_op, neg_a, neg_b, div_zero, ovf, early_out, fast;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, dvd_load;
    logic [XLEN-1:0] fast_q_d, fast_r_d, quo_fix_d, rem_fix_d, q_sgn, r_sgn;
    logic [XLEN-1:0] step_rem;
    logic            step_q;

    // Operand conditioning at the accept edge.
    assign word_op  = WORD_EN & divw;
    assign a_ext    = word_op ? (div_signed ? sext_w(dividend) : zext_w(dividend)) : dividend;
    assign b_ext    = word_op ? (div_signed ? sext_w(divisor)  : zext_w(divisor))  : divisor;
    assign neg_a    = div_signed & a_ext[XLEN-1];
    assign neg_b    = div_signed & b_ext[XLEN-1];
    assign mag_a    = neg_a ? -a_ext : a_ext;
    assign mag_b    = neg_b ? -b_ext : b_ext;
    assign dvd_load = word_op ? (mag_a << WORD_BITS) : mag_a;

    assign div_zero = (b_ext == '0);
    assign ovf      = div_signed && (b_ext == '1) &&
                      (word_op ? (a_ext[WORD_BITS-1:0] == MIN_W) : (a_ext == MIN_X));
`ifdef DIV_EARLY_OUT_EN
    assign early_out = !div_zero && (mag_a < mag_b);
`else
    assign early_out = 1'b0;
`endif
    assign fast = div_zero | ovf | early_out;

    always_comb begin
        fast_q_d = '0;
        fast_r_d = word_op ? sext_w(dividend) : dividend;
        if (div_zero) begin
            fast_q_d = '1;
        end else if (ovf) begin
            fast_q_d = a_ext;
            fast_r_d = '0;
        end
    end

    // Sign fix-up; word results always sign-extend bit 31, signed or not.
    assign q_sgn     = neg_q_q ? -dvd_q : dvd_q;
    assign r_sgn     = neg_r_q ? -rem_q : rem_q;
    assign quo_fix_d = word_q ? sext_w(q_sgn) : q_sgn;
    assign rem_fix_d = word_q ? sext_w(r_sgn) : r_sgn;

    div_step #(.W(XLEN)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[XLEN-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            word_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        word_q     <= word_op;
                        neg_q_q    <= neg_a ^ neg_b;
                        neg_r_q    <= neg_a;
                        dvd_q      <= dvd_load;
                        dvs_q      <= mag_b;
                        rem_q      <= '0;
                        if (fast) begin
                            state_q     <= DONE;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b1;
                            quotient_q  <= fast_q_d;
                            remainder_q <= fast_r_d;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= step_count(word_op, XLEN) - CNT_W'(1);
                        end
                    end
                end
                CALC: begin
                    // Quotient bits shift into the vacated low end of the dividend register.
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[XLEN-2:0], step_q};
                    if (cnt_q == '0) state_q <= FIX;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    quotient_q  <= quo_fix_d;
                    remainder_q <= rem_fix_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed and random checks of iter_div_unit against a plain-arithmetic reference model.
module tb_iter_div_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, div_signed, divw, out_ready;
    logic [63:0] dividend, divisor, quotient, remainder;
    logic        in_ready, out_valid;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iter_div_unit #(.XLEN(64), .WORD_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .div_signed (div_signed),
        .divw       (divw),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: native SV division plus the architectural special cases.
    task automatic ref_div(input bit sgn, input bit w, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] q, output logic [63:0] r, output int lat);
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa, sb, ea, eb;
        logic [31:0]        q32, r32;
        logic [63:0]        ma, mb;
        bit                 fast;
        fast = 1'b0;
        if (w) begin
            sa32 = a[31:0];
            sb32 = b[31:0];
            if (b[31:0] == 32'h0) begin
                q32 = 32'hFFFF_FFFF; r32 = a[31:0]; fast = 1'b1;
            end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                q32 = a[31:0]; r32 = 32'h0; fast = 1'b1;
            end else if (sgn) begin
                q32 = sa32 / sb32; r32 = sa32 % sb32;
            end else begin
                q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
            end
            q  = {{32{q32[31]}}, q32};
            r  = {{32{r32[31]}}, r32};
            ea = sgn ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]};
            eb = sgn ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]};
            lat = 34;
        end else begin
            sa = a;
            sb = b;
            if (b == 64'h0) begin
                q = '1; r = a; fast = 1'b1;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 64'h0; fast = 1'b1;
            end else if (sgn) begin
                q = sa / sb; r = sa % sb;
            end else begin
                q = a / b; r = a % b;
            end
            ea = a;
            eb = b;
            lat = 66;
        end
        ma = (sgn && ea < 0) ? -ea : ea;
        mb = (sgn && eb < 0) ? -eb : eb;
        if (fast) lat = 1;
`ifdef DIV_EARLY_OUT_EN
        if (!fast && ma < mb) lat = 1;
`endif
    endtask

    // Drive an operation and return just after its accept edge.
    task automatic start_op(input string tag, input bit sgn, input bit w,
                            input logic [63:0] a, input logic [63:0] b);
        int k;
        @(negedge clk);
        div_signed = sgn; divw = w; dividend = a; divisor = b; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
    endtask

    task automatic do_op(input string tag, input bit sgn, input bit w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eq, input logic [63:0] er,
                         input int elat, input int hold);
        int lat;
        start_op(tag, sgn, w, a, b);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_valid = 1'b0;
                chk({tag, "_busy"}, 64'(in_ready), 64'd0);
            end
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_hs"}, {62'h0, out_valid, in_ready}, 64'd2);
            chk({tag, "_hold_q"}, quotient, eq);
            chk({tag, "_hold_r"}, remainder, er);
        end
        out_ready = 1'b1;
        if (hold > 0) chk({tag, "_pre_handoff"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_handoff"}, {62'h0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] a, b, q, r;
        int          lat, seen;
        bit          s, w;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; div_signed = 1'b0; divw = 1'b0;
        out_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_q", quotient, 64'd0);
        chk("rst_r", remainder, 64'd0);
        rst = 1'b0;

        do_op("divu_100_7", 0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 66, 0);
        do_op("div_m100_7", 1, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
              64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
        do_op("divw_ovf", 1, 1, 64'hFFFF_FFFF_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 64'd0, 1, 0);
        do_op("divu_5_0", 0, 0, 64'd5, 64'd0, '1, 64'd5, 1, 0);
        do_op("divuw_0", 0, 1, 64'h1_0000_0005, 64'd0, '1, 64'd5, 1, 0);
        do_op("divw_m7_2", 1, 1, 64'h1234_5678_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, '1, 34, 0);
        do_op("divuw_sext", 0, 1, 64'h0_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 34, 0);
        do_op("div64_ovf", 1, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64'd0, 1, 0);

        // Flush mid-calculation, with a competing request on the flush cycle.
        start_op("flush_op", 1, 0, 64'd1000, 64'd3);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        flush = 1'b1; in_valid = 1'b1; dividend = 64'd50; divisor = 64'd5;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_state", {62'h0, out_valid, in_ready}, 64'd1);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);
        do_op("after_flush", 1, 0, 64'd9, 64'd3, 64'd3, 64'd0, 66, 0);

        do_op("divu_hold", 0, 0, 64'd20, 64'd3, 64'd6, 64'd2, 66, 10);
`ifdef DIV_EARLY_OUT_EN
        do_op("divu_3_10", 0, 0, 64'd3, 64'd10, 64'd0, 64'd3, 1, 0);
`else
        do_op("divu_3_10", 0, 0, 64'd3, 64'd10, 64'd0, 64'd3, 66, 0);
`endif

        // Reset in the middle of a calculation discards it.
        start_op("rst_mid", 0, 0, 64'd1000, 64'd7);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_hs", {62'h0, out_valid, in_ready}, 64'd1);
        chk("rstmid_q", quotient, 64'd0);
        chk("rstmid_r", remainder, 64'd0);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rstmid_no_valid", 64'(seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0:       b = 64'd0;
                1:       b = '1;
                2:       b = 64'($urandom_range(1, 15));
                3:       b = a >> $urandom_range(1, 40);
                default: b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            endcase
            if ($urandom_range(0, 7) == 0) a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
            ref_div(s, w, a, b, q, r, lat);
            do_op($sformatf("rnd%0d", i), s, w, a, b, q, r, lat, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
